// File: rtl/ck2_mon.sv
`default_nettype none
// ============================================================================
// Module   : ck2_mon
// Purpose  : CPU access/execution monitor with per-region X/R/W permissions,
//            lockable register map, saturating violation counter, first
//            violation capture and sticky trap request.
// Revision : 1.0 - initial release
// ============================================================================
module ck2_mon #(
    parameter int NUM_REGIONS  = 4,
    parameter int COUNT_WIDTH  = 16,
    parameter bit DEFAULT_DENY = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_valid,
    input  logic        cpu_instr,
    input  logic        cpu_write,
    input  logic [31:0] cpu_addr,
    output logic        force_trap,
    input  logic        cs,
    input  logic        we,
    input  logic [7:0]  address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready
);

    localparam logic [31:0] c_NAME0     = 32'h636b3220;
    localparam logic [31:0] c_NAME1     = 32'h6d6f6e20;
    localparam logic [31:0] c_VERSION   = 32'h00000001;
    localparam logic [7:0]  c_ADDR_NAME0 = 8'h00;
    localparam logic [7:0]  c_ADDR_NAME1 = 8'h01;
    localparam logic [7:0]  c_ADDR_VER   = 8'h02;
    localparam logic [7:0]  c_ADDR_CTRL  = 8'h08;
    localparam logic [7:0]  c_ADDR_COUNT = 8'h09;
    localparam logic [7:0]  c_ADDR_VADDR = 8'h0a;
    localparam logic [7:0]  c_ADDR_VINFO = 8'h0b;
    localparam logic [3:0]  c_NO_REGION  = 4'hf;
    localparam logic [COUNT_WIDTH-1:0] c_COUNT_MAX = {COUNT_WIDTH{1'b1}};

    logic                   r_enable;
    logic                   r_trap_en;
    logic                   r_lock;
    logic                   r_force_trap;
    logic                   r_valid_d;
    logic                   r_captured;
    logic [COUNT_WIDTH-1:0] r_count;
    logic [31:0]            r_viol_addr;
    logic [2:0]             r_viol_kind;
    logic [3:0]             r_viol_region;
    logic [31:0]            r_first [NUM_REGIONS];
    logic [31:0]            r_last  [NUM_REGIONS];
    logic [3:0]             r_perm  [NUM_REGIONS];

    logic        w_bus_wr;
    logic        w_wr_ctrl;
    logic        w_wr_count;
    logic        w_reg_sel;
    logic [3:0]  w_reg_idx;
    logic [1:0]  w_reg_off;
    logic        w_matched;
    logic [3:0]  w_hit_region;
    logic [2:0]  w_hit_perm;
    logic [2:0]  w_kind;
    logic        w_new_txn;
    logic        w_viol;
    logic [31:0] w_rdata;

    assign w_bus_wr   = cs & we;
    assign w_wr_ctrl  = w_bus_wr & (address == c_ADDR_CTRL);
    assign w_wr_count = w_bus_wr & (address == c_ADDR_COUNT);
    assign w_reg_sel  = (address[7:6] == 2'b01);
    assign w_reg_idx  = address[5:2];
    assign w_reg_off  = address[1:0];

    // Kind bit positions line up with PERM {W,R,X}, so the check is a mask.
    assign w_kind    = cpu_instr ? 3'b001 : (cpu_write ? 3'b100 : 3'b010);
    assign w_new_txn = cpu_valid & ~r_valid_d;

    always_comb begin
        w_matched    = 1'b0;
        w_hit_region = c_NO_REGION;
        w_hit_perm   = 3'b000;
        // Descending scan so the lowest matching index wins.
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if (r_perm[i][3] && (cpu_addr >= r_first[i]) && (cpu_addr <= r_last[i])) begin
                w_matched    = 1'b1;
                w_hit_region = 4'(i);
                w_hit_perm   = r_perm[i][2:0];
            end
        end
    end

    assign w_viol = r_enable & w_new_txn &
                    (w_matched ? ~|(w_hit_perm & w_kind) : DEFAULT_DENY);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_enable      <= 1'b0;
            r_trap_en     <= 1'b0;
            r_lock        <= 1'b0;
            r_force_trap  <= 1'b0;
            r_valid_d     <= 1'b0;
            r_captured    <= 1'b0;
            r_count       <= '0;
            r_viol_addr   <= 32'h0;
            r_viol_kind   <= 3'b000;
            r_viol_region <= 4'h0;
            for (int i = 0; i < NUM_REGIONS; i++) begin
                r_first[i] <= 32'h0;
                r_last[i]  <= 32'h0;
                r_perm[i]  <= 4'h0;
            end
        end else begin
            r_valid_d <= cpu_valid;

            if (w_wr_ctrl) begin
                if (!r_lock) begin
                    r_enable  <= write_data[0];
                    r_trap_en <= write_data[1];
                end
                if (write_data[2]) begin
                    r_lock <= 1'b1;
                end
            end

            for (int i = 0; i < NUM_REGIONS; i++) begin
                if (w_bus_wr && !r_lock && w_reg_sel && (w_reg_idx == 4'(i))) begin
                    case (w_reg_off)
                        2'd0:    r_first[i] <= write_data;
                        2'd1:    r_last[i]  <= write_data;
                        2'd2:    r_perm[i]  <= write_data[3:0];
                        default: ;
                    endcase
                end
            end

            // A violation in the same cycle as a COUNT clear survives the clear.
            if (w_viol) begin
                if (w_wr_count) begin
                    r_count <= COUNT_WIDTH'(1);
                end else if (r_count != c_COUNT_MAX) begin
                    r_count <= r_count + COUNT_WIDTH'(1);
                end
                if (!r_captured || w_wr_count) begin
                    r_captured    <= 1'b1;
                    r_viol_addr   <= cpu_addr;
                    r_viol_kind   <= w_kind;
                    r_viol_region <= w_hit_region;
                end
                if (r_trap_en) begin
                    r_force_trap <= 1'b1;
                end
            end else if (w_wr_count) begin
                r_count       <= '0;
                r_captured    <= 1'b0;
                r_viol_addr   <= 32'h0;
                r_viol_kind   <= 3'b000;
                r_viol_region <= 4'h0;
            end
        end
    end

    always_comb begin
        w_rdata = 32'h0;
        case (address)
            c_ADDR_NAME0: w_rdata = c_NAME0;
            c_ADDR_NAME1: w_rdata = c_NAME1;
            c_ADDR_VER:   w_rdata = c_VERSION;
            c_ADDR_CTRL:  w_rdata = {28'h0, r_force_trap, r_lock, r_trap_en, r_enable};
            c_ADDR_COUNT: w_rdata = 32'(r_count);
            c_ADDR_VADDR: w_rdata = r_viol_addr;
            c_ADDR_VINFO: w_rdata = {24'h0, r_captured, r_viol_kind, r_viol_region};
            default: begin
                for (int i = 0; i < NUM_REGIONS; i++) begin
                    if (w_reg_sel && (w_reg_idx == 4'(i))) begin
                        case (w_reg_off)
                            2'd0:    w_rdata = r_first[i];
                            2'd1:    w_rdata = r_last[i];
                            2'd2:    w_rdata = {28'h0, r_perm[i]};
                            default: w_rdata = 32'h0;
                        endcase
                    end
                end
            end
        endcase
    end

    assign read_data  = cs ? w_rdata : 32'h0;
    assign ready      = cs;
    assign force_trap = r_force_trap;

endmodule
`default_nettype wire

// File: doc/ck2_mon.md
Name: ck2_mon

Overview:
- Parametrised CPU access/execution monitor and violation logger for the CrypTkey SoC, sitting beside the top-level control core.
- Provides NUM_REGIONS address windows. Each window has its own execute/read/write permissions.
- Register map is lockable. Violation counter saturates. First violation is captured. Trap output is sticky.
- Slave on the standard core bus (cs/we/address/write_data/read_data/ready).

Parameters:
NUM_REGIONS, 4, number of protection windows; legal range 1..16
COUNT_WIDTH, 16, width of saturating violation counter; legal range 1..32
DEFAULT_DENY, 0, 1 = access matching no enabled region is a violation; 0 = allowed

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
cpu_valid  input  1  CPU bus transaction active (held until complete)
cpu_instr  input  1  transaction is an instruction fetch
cpu_write  input  1  transaction is a data write (ignored when cpu_instr=1)
cpu_addr  input  32  transaction address
force_trap  output  1  sticky trap request to CPU
cs  input  1  core select
we  input  1  write enable
address  input  8  word address
write_data  input  32  write data
read_data  output  32  read data
ready  output  1  access complete

Behaviour:
- Interface: one clock, clk. reset is asynchronous and active-high. All registers clear immediately on reset assertion.
- Reset values: force_trap=0, enable=0, lock=0, trap_en=0, all region FIRST/LAST/PERM=0, count=0, viol_addr=0, viol_info=0, valid_d=0.
- Bus: ready = cs, combinational. Zero-wait reads. read_data=0 when cs=0 or the address is unmapped. Writes to read-only or unmapped addresses are ignored.
- Register map:
  - 0x00 NAME0 = 0x636b3220 ("ck2 "); 0x01 NAME1 = 0x6d6f6e20 ("mon "); 0x02 VERSION = 0x00000001.
  - 0x08 CTRL write: bit0 enable, bit1 trap_en, bit2 lock. Bits 0–1 are writable only while lock=0. bit2 is set-only: once set, it clears only on reset.
  - 0x08 CTRL read: {28'h0, force_trap, lock, trap_en, enable}.
  - 0x09 COUNT: read returns zero-extended count. Any write clears count, viol_addr, viol_info and the captured flag; force_trap is not cleared. Writes are allowed while locked.
  - 0x0a VIOL_ADDR: read-only.
  - 0x0b VIOL_INFO: read-only, {24'h0, captured, kind[2:0], region[3:0]}.
    - kind is one-hot: 001 exec, 010 read, 100 write.
    - region = 4'hf when no region matched (DEFAULT_DENY hit).
  - Region i at 0x40+4i: +0 FIRST, +1 LAST, +2 PERM {28'h0, en, W, R, X}.
    - Writable only while lock=0. Readable always.
    - Addresses for i >= NUM_REGIONS are unmapped.
- Check, combinational per cycle:
  - Region i matches when en_i, FIRST_i <= cpu_addr <= LAST_i (unsigned, inclusive).
  - If FIRST > LAST, the region never matches.
  - Lowest matching index decides.
  - Required permission: X if cpu_instr, else W if cpu_write, else R.
  - viol = enable & new_txn & (matched ? !perm : DEFAULT_DENY).
- new_txn = cpu_valid & !valid_d, where valid_d is cpu_valid registered. A multi-cycle transaction is evaluated once, on its first cycle only.
- On viol, effective at the next clk edge (latency 1):
  - count increments, saturating at 2^COUNT_WIDTH-1 (no wrap).
  - If captured=0: capture cpu_addr, kind and region, and set captured. Later violations do not overwrite.
  - If trap_en=1: force_trap set. Sticky until reset.
- Same-cycle bus write and violation:
  - COUNT clear loses to the violation: the result is count=1 and the new capture.
  - Region/CTRL writes take effect at the same edge, so the violation is judged on the old values.
- enable=0: no checking, no counting, force_trap holds its value.

Test Plan:
- Reset, then read 0x00/0x01/0x02/0x08 -> 0x636b3220, 0x6d6f6e20, 0x00000001, 0x0.
- Region0 FIRST=0x40000000, LAST=0x4000ffff, PERM=0xb (en,W,X denied R? no: en+R+X... use 0xd = en,W,X); CTRL=0x3; data read at 0x40000100 held 3 cycles -> force_trap=1 one cycle after first valid cycle, COUNT=1, VIOL_ADDR=0x40000100, VIOL_INFO=0x00000a0... i.e. captured=1,kind=010,region=0 -> 0xa0.
- Overlap: region0 0x1000–0x1fff PERM=0x8 (no X), region1 0x0–0xffff PERM=0xf; fetch at 0x1800 -> violation, region=0; fetch at 0x2000 -> none.
- Lock: write CTRL=0x7, then region0 FIRST=0x1234 and CTRL=0x0 -> FIRST unchanged, CTRL read bits[2:0]=111; COUNT write still clears.
- COUNT_WIDTH=2: 5 violating transactions -> COUNT=3; VIOL_ADDR holds first address.
- DEFAULT_DENY=1, no regions enabled, trap_en=0: read at 0x0 -> COUNT=1, VIOL_INFO region=0xf, force_trap stays 0. Assert reset mid-transaction -> all registers 0 immediately.
